// File: rtl/ir_load_ctrl.sv
// ----------------------------------------------------------------------------
// ir_load_ctrl
//
// Sequencer for the instruction register file (regfile_ir).
// After reset or a load request it copies 2**IR_ADDR_WIDTH consecutive words
// from instruction memory into regfile_ir, one memory read and one regfile
// write per entry. It then enters WORK and serves pipelined instruction
// fetches out of regfile_ir.
//
// This block is the only driver of regfile_ir's inputs. The regfile
// registers its address and store inputs, and presents rf_data_out
// combinationally from its registered address.
//
// Ports
//   clk               clock, rising edge
//   rst_n             synchronous, active-low reset
//   start             load request pulse (honoured in IDLE and WORK)
//   base_addr         first memory word to load, sampled with start
//   mem_req/mem_addr  memory read request; held until mem_ack
//   mem_ack/mem_rdata read completion; data valid with the ack
//   rf_mode           regfile write enable (registered)
//   rf_address        regfile address (registered)
//   rf_data_in        regfile write data (registered)
//   rf_data_out       regfile read data
//   fetch_valid       fetch request
//   fetch_addr        fetch entry index
//   fetch_ready       fetch can be accepted this cycle
//   fetch_data        fetched instruction (registered)
//   fetch_data_valid  one-cycle strobe per accepted fetch
//   init_finished     regfile is loaded and fetches are served
//   busy              a load is in progress
// ----------------------------------------------------------------------------
module ir_load_ctrl #(
    parameter int IRR_WIDTH      = 32,
    parameter int IR_ADDR_WIDTH  = 4,
    parameter int MEM_ADDR_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [MEM_ADDR_WIDTH-1:0] base_addr,
    output logic                      mem_req,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    input  logic                      mem_ack,
    input  logic [IRR_WIDTH-1:0]      mem_rdata,
    output logic                      rf_mode,
    output logic [IR_ADDR_WIDTH-1:0]  rf_address,
    output logic [IRR_WIDTH-1:0]      rf_data_in,
    input  logic [IRR_WIDTH-1:0]      rf_data_out,
    input  logic                      fetch_valid,
    input  logic [IR_ADDR_WIDTH-1:0]  fetch_addr,
    output logic                      fetch_ready,
    output logic [IRR_WIDTH-1:0]      fetch_data,
    output logic                      fetch_data_valid,
    output logic                      init_finished,
    output logic                      busy
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_REQ = 3'd1,
        LOAD_WR  = 3'd2,
        DRAIN    = 3'd3,
        WORK     = 3'd4
    } state_t;

    localparam logic [IR_ADDR_WIDTH-1:0] IDX_LAST = '1;

    state_t                      state_reg, state_next;
    logic [MEM_ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic [IR_ADDR_WIDTH-1:0]    idx_reg, idx_next;
    logic [IRR_WIDTH-1:0]        data_reg, data_next;
    // DRAIN lasts two cycles: the regfile's input register and its store
    // stage each need one edge to retire the final write.
    logic                        drain_cnt_reg, drain_cnt_next;

    logic                        rf_mode_reg, rf_mode_next;
    logic [IR_ADDR_WIDTH-1:0]    rf_address_reg, rf_address_next;
    logic [IRR_WIDTH-1:0]        rf_data_in_reg, rf_data_in_next;

    // Fetch pipeline: v1 = address on rf_address, v2 = address captured by
    // the regfile (rf_data_out now valid), then fetch_data is registered.
    logic                        fetch_accept;
    logic                        fetch_v1_reg;
    logic                        fetch_v2_reg;
    logic [IRR_WIDTH-1:0]        fetch_data_reg;
    logic                        fetch_data_valid_reg;

    logic [MEM_ADDR_WIDTH-1:0]   mem_addr_sum;

    // Address wraps modulo 2**MEM_ADDR_WIDTH by truncation.
    assign mem_addr_sum = addr_reg + MEM_ADDR_WIDTH'(idx_reg);

    // ------------------------------------------------------------------
    // Next-state and datapath decode
    // ------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        addr_next       = addr_reg;
        idx_next        = idx_reg;
        data_next       = data_reg;
        drain_cnt_next  = drain_cnt_reg;
        rf_mode_next    = 1'b0;
        rf_address_next = rf_address_reg;
        rf_data_in_next = rf_data_in_reg;
        fetch_accept    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    addr_next  = base_addr;
                    idx_next   = '0;
                    state_next = LOAD_REQ;
                end
            end

            LOAD_REQ: begin
                if (mem_ack) begin
                    data_next  = mem_rdata;
                    state_next = LOAD_WR;
                end
            end

            LOAD_WR: begin
                rf_mode_next    = 1'b1;
                rf_address_next = idx_reg;
                rf_data_in_next = data_reg;
                if (idx_reg == IDX_LAST) begin
                    drain_cnt_next = 1'b0;
                    state_next     = DRAIN;
                end else begin
                    idx_next   = idx_reg + 1'b1;
                    state_next = LOAD_REQ;
                end
            end

            DRAIN: begin
                if (drain_cnt_reg) begin
                    state_next = WORK;
                end else begin
                    drain_cnt_next = 1'b1;
                end
            end

            WORK: begin
                // A load request takes priority; fetch_ready is low while
                // start is high, so no fetch is accepted in that cycle.
                if (start) begin
                    addr_next  = base_addr;
                    idx_next   = '0;
                    state_next = LOAD_REQ;
                end else if (fetch_valid) begin
                    fetch_accept    = 1'b1;
                    rf_address_next = fetch_addr;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg            <= IDLE;
            addr_reg             <= '0;
            idx_reg              <= '0;
            data_reg             <= '0;
            drain_cnt_reg        <= 1'b0;
            rf_mode_reg          <= 1'b0;
            rf_address_reg       <= '0;
            rf_data_in_reg       <= '0;
            fetch_v1_reg         <= 1'b0;
            fetch_v2_reg         <= 1'b0;
            fetch_data_reg       <= '0;
            fetch_data_valid_reg <= 1'b0;
        end else begin
            state_reg            <= state_next;
            addr_reg             <= addr_next;
            idx_reg              <= idx_next;
            data_reg             <= data_next;
            drain_cnt_reg        <= drain_cnt_next;
            rf_mode_reg          <= rf_mode_next;
            rf_address_reg       <= rf_address_next;
            rf_data_in_reg       <= rf_data_in_next;
            // In-flight fetches complete regardless of a reload starting.
            fetch_v1_reg         <= fetch_accept;
            fetch_v2_reg         <= fetch_v1_reg;
            fetch_data_valid_reg <= fetch_v2_reg;
            if (fetch_v2_reg) begin
                fetch_data_reg <= rf_data_out;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mem_req          = (state_reg == LOAD_REQ);
    assign mem_addr         = mem_req ? mem_addr_sum : '0;
    assign rf_mode          = rf_mode_reg;
    assign rf_address       = rf_address_reg;
    assign rf_data_in       = rf_data_in_reg;
    assign fetch_ready      = (state_reg == WORK) && !start;
    assign fetch_data       = fetch_data_reg;
    assign fetch_data_valid = fetch_data_valid_reg;
    assign init_finished    = (state_reg == WORK);
    assign busy             = (state_reg == LOAD_REQ) || (state_reg == LOAD_WR) ||
                              (state_reg == DRAIN);

endmodule

// File: tb/tb_ir_load_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ir_load_ctrl
//
// Directed bench for ir_load_ctrl. Contains a memory responder with
// programmable ack delay (data = 0xA000_0000 + address), a regfile_ir model
// (registered address and store, combinational read), and a monitor that
// logs writes, memory acks and fetch strobes. One task per scenario.
// ----------------------------------------------------------------------------
module tb_ir_load_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] base_addr = 16'h0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        rf_mode;
    logic [3:0]  rf_address;
    logic [31:0] rf_data_in;
    logic [31:0] rf_data_out;
    logic        fetch_valid = 1'b0;
    logic [3:0]  fetch_addr = 4'h0;
    logic        fetch_ready;
    logic [31:0] fetch_data;
    logic        fetch_data_valid;
    logic        init_finished;
    logic        busy;

    int errors = 0;
    int checks = 0;

    // memory responder controls
    int ack_delay = 1;
    bit mem_enable = 1'b1;
    bit force_ack = 1'b0;

    // monitor logs
    logic [3:0]  wr_addr[$];
    logic [31:0] wr_data[$];
    logic [15:0] ack_addr[$];
    int          req_len[$];
    logic [31:0] strobe_data[$];
    int          strobe_cyc[$];
    int          last_wr_cyc = 0;
    int          init_rise_cyc = 0;
    int          busy_fall_cyc = 0;
    int          max_run = 0;
    int          cyc = 0;

    ir_load_ctrl #(
        .IRR_WIDTH     (32),
        .IR_ADDR_WIDTH (4),
        .MEM_ADDR_WIDTH(16)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .base_addr       (base_addr),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_ack         (mem_ack),
        .mem_rdata       (mem_rdata),
        .rf_mode         (rf_mode),
        .rf_address      (rf_address),
        .rf_data_in      (rf_data_in),
        .rf_data_out     (rf_data_out),
        .fetch_valid     (fetch_valid),
        .fetch_addr      (fetch_addr),
        .fetch_ready     (fetch_ready),
        .fetch_data      (fetch_data),
        .fetch_data_valid(fetch_data_valid),
        .init_finished   (init_finished),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // regfile_ir model
    logic [31:0] rf_mem [16];
    logic [3:0]  rf_addr_q = 4'h0;
    always @(posedge clk) begin
        if (rf_mode) rf_mem[rf_address] <= rf_data_in;
        rf_addr_q <= rf_address;
    end
    assign rf_data_out = rf_mem[rf_addr_q];

    // memory responder, acts on the falling edge
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        forever begin
            @(negedge clk);
            if (force_ack) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'hDEAD_BEEF;
            end else if (mem_enable && mem_req && !mem_ack) begin
                if (wait_cnt >= ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = 32'hA000_0000 + {16'h0, mem_addr};
                    wait_cnt  = 0;
                end else begin
                    mem_ack  = 1'b0;
                    wait_cnt = wait_cnt + 1;
                end
            end else begin
                mem_ack = 1'b0;
                if (!mem_req) wait_cnt = 0;
            end
        end
    end

    // monitor, samples just after the falling edge
    initial begin
        int  run;
        int  req_run;
        bit  prev_init;
        bit  prev_busy;
        run = 0; req_run = 0; prev_init = 0; prev_busy = 0;
        forever begin
            @(negedge clk);
            #1;
            if (rf_mode) begin
                wr_addr.push_back(rf_address);
                wr_data.push_back(rf_data_in);
                last_wr_cyc = cyc;
                run = run + 1;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (mem_req) req_run = req_run + 1;
            if (mem_req && mem_ack) begin
                ack_addr.push_back(mem_addr);
                req_len.push_back(req_run);
            end
            if (!mem_req || mem_ack) req_run = 0;
            if (fetch_data_valid) begin
                strobe_data.push_back(fetch_data);
                strobe_cyc.push_back(cyc);
            end
            if (init_finished && !prev_init) init_rise_cyc = cyc;
            if (!busy && prev_busy) busy_fall_cyc = cyc;
            prev_init = init_finished;
            prev_busy = busy;
        end
    end

    // inputs change 2 time units after the falling edge
    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic do_start(input logic [15:0] b);
        step();
        base_addr = b;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_init(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (init_finished) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    // --------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        step();
        start = 1'b1;
        base_addr = 16'h1234;
        step();
        start = 1'b0;
        step();
        checks++;
        if ({mem_req, mem_addr, rf_mode, rf_address, rf_data_in, fetch_ready,
             fetch_data, fetch_data_valid, init_finished, busy} !== 90'h0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b init=%b mem_req=%b rf_mode=%b expected all zero",
                     busy, init_finished, mem_req, rf_mode);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b mem_req=%b expected 0 0", busy, mem_req);
        end
        $display("test_reset done");
    endtask

    // --------------------------------------------------------------------
    task automatic test_load_basic();
        int w0, a0, r0, n;
        bit ok;
        ack_delay = 1;
        w0 = wr_addr.size(); a0 = ack_addr.size(); r0 = req_len.size();
        do_start(16'h0100);
        wait_init(400, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL load1_timeout: init_finished=%b expected 1", init_finished);
        end
        n = wr_addr.size() - w0;
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL load1_write_count: got %0d expected 16", n);
        end
        if (n == 16 && ack_addr.size() - a0 == 16) begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (wr_addr[w0+i] !== 4'(i) || wr_data[w0+i] !== 32'hA000_0100 + i) begin
                    errors++;
                    $display("FAIL load1_write[%0d]: got addr=%0d data=%h expected addr=%0d data=%h",
                             i, wr_addr[w0+i], wr_data[w0+i], i, 32'hA000_0100 + i);
                end
                checks++;
                if (ack_addr[a0+i] !== 16'h0100 + 16'(i) || req_len[r0+i] !== 2) begin
                    errors++;
                    $display("FAIL load1_mem[%0d]: got mem_addr=%h req_cycles=%0d expected %h 2",
                             i, ack_addr[a0+i], req_len[r0+i], 16'h0100 + 16'(i));
                end
            end
        end
        checks++;
        if (max_run !== 1) begin
            errors++;
            $display("FAIL load1_pulse_width: got %0d expected 1", max_run);
        end
        checks++;
        if (init_rise_cyc - last_wr_cyc !== 2) begin
            errors++;
            $display("FAIL load1_init_delay: got %0d expected 2", init_rise_cyc - last_wr_cyc);
        end
        checks++;
        if (busy_fall_cyc !== init_rise_cyc) begin
            errors++;
            $display("FAIL load1_busy_fall: got cycle %0d expected %0d", busy_fall_cyc, init_rise_cyc);
        end
        checks++;
        if (busy !== 1'b0 || fetch_ready !== 1'b1) begin
            errors++;
            $display("FAIL load1_work: got busy=%b fetch_ready=%b expected 0 1", busy, fetch_ready);
        end
        $display("test_load_basic done: writes=%0d", n);
    endtask

    // --------------------------------------------------------------------
    task automatic test_back_to_back();
        int s0, n;
        int acc[3];
        logic [3:0]  fa[3];
        logic [31:0] exp_d[3];
        fa[0] = 4'd3; fa[1] = 4'd4; fa[2] = 4'd15;
        exp_d[0] = 32'hA000_0103; exp_d[1] = 32'hA000_0104; exp_d[2] = 32'hA000_010F;
        s0 = strobe_data.size();
        for (int i = 0; i < 3; i++) begin
            step();
            fetch_valid = 1'b1;
            fetch_addr = fa[i];
            #1;
            acc[i] = cyc;
            checks++;
            if (fetch_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready[%0d]: got %b expected 1", i, fetch_ready);
            end
        end
        step();
        fetch_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        n = strobe_data.size() - s0;
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d expected 3", n);
        end
        if (n == 3) begin
            for (int i = 0; i < 3; i++) begin
                // strobe is visible in the cycle after the second edge
                // following the accepting edge
                checks++;
                if (strobe_data[s0+i] !== exp_d[i] || strobe_cyc[s0+i] !== acc[i] + 3) begin
                    errors++;
                    $display("FAIL b2b_fetch[%0d]: got data=%h cyc=%0d expected data=%h cyc=%0d",
                             i, strobe_data[s0+i], strobe_cyc[s0+i], exp_d[i], acc[i] + 3);
                end
            end
        end
        checks++;
        if (fetch_data_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle_strobe: got %b expected 0", fetch_data_valid);
        end
        $display("test_back_to_back done: strobes=%0d", n);
    endtask

    // --------------------------------------------------------------------
    task automatic test_wrap();
        int a0, w0, s0;
        bit ok;
        logic [15:0] ea;
        ack_delay = 1;
        a0 = ack_addr.size(); w0 = wr_addr.size();
        do_start(16'hFFFE);
        wait_init(400, ok);
        checks++;
        if (!ok || ack_addr.size() - a0 !== 16 || wr_addr.size() - w0 !== 16) begin
            errors++;
            $display("FAIL wrap_load: got done=%b acks=%0d writes=%0d expected 1 16 16",
                     ok, ack_addr.size() - a0, wr_addr.size() - w0);
        end else begin
            for (int i = 0; i < 16; i++) begin
                ea = 16'hFFFE + 16'(i);
                checks++;
                if (ack_addr[a0+i] !== ea || wr_data[w0+i] !== {16'hA000, ea}) begin
                    errors++;
                    $display("FAIL wrap_addr[%0d]: got mem_addr=%h data=%h expected %h %h",
                             i, ack_addr[a0+i], wr_data[w0+i], ea, {16'hA000, ea});
                end
            end
        end
        s0 = strobe_data.size();
        step();
        fetch_valid = 1'b1;
        fetch_addr = 4'd2;
        step();
        fetch_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (strobe_data.size() - s0 !== 1) begin
            errors++;
            $display("FAIL wrap_fetch_count: got %0d expected 1", strobe_data.size() - s0);
        end else if (strobe_data[s0] !== 32'hA000_0000) begin
            errors++;
            $display("FAIL wrap_fetch_entry2: got %h expected a0000000", strobe_data[s0]);
        end
        $display("test_wrap done");
    endtask

    // --------------------------------------------------------------------
    task automatic test_reset_midload();
        int w0, w1, a1;
        bit ok;
        ack_delay = 1;
        w0 = wr_addr.size();
        do_start(16'h0300);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (wr_addr.size() - w0 >= 7 && mem_req) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        checks++;
        if (!ok || wr_addr.size() - w0 !== 7) begin
            errors++;
            $display("FAIL midload_reach: got writes=%0d mem_req=%b expected 7 1",
                     wr_addr.size() - w0, mem_req);
        end
        rst_n = 1'b0;
        mem_enable = 1'b0;
        step();
        checks++;
        if ({mem_req, mem_addr, rf_mode, rf_address, rf_data_in, fetch_ready,
             fetch_data, fetch_data_valid, init_finished, busy} !== 90'h0) begin
            errors++;
            $display("FAIL midload_reset_outputs: got busy=%b mem_req=%b rf_address=%0d fetch_data=%h expected all zero",
                     busy, mem_req, rf_address, fetch_data);
        end
        rst_n = 1'b1;
        force_ack = 1'b1;
        step();
        force_ack = 1'b0;
        checks++;
        if (mem_ack !== 1'b1 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL midload_late_ack: got mem_ack=%b mem_req=%b expected 1 0", mem_ack, mem_req);
        end
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (wr_addr.size() - w0 !== 7 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midload_no_write: got writes=%0d busy=%b expected 7 0",
                     wr_addr.size() - w0, busy);
        end
        mem_enable = 1'b1;
        w1 = wr_addr.size(); a1 = ack_addr.size();
        do_start(16'h0300);
        wait_init(400, ok);
        checks++;
        if (!ok || wr_addr.size() - w1 !== 16 || ack_addr.size() - a1 !== 16) begin
            errors++;
            $display("FAIL midload_reload: got done=%b writes=%0d expected 1 16", ok, wr_addr.size() - w1);
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (wr_addr[w1+i] !== 4'(i) || wr_data[w1+i] !== 32'hA000_0300 + i ||
                    ack_addr[a1+i] !== 16'h0300 + 16'(i)) begin
                    errors++;
                    $display("FAIL midload_entry[%0d]: got addr=%0d data=%h expected %0d %h",
                             i, wr_addr[w1+i], wr_data[w1+i], i, 32'hA000_0300 + i);
                end
            end
        end
        $display("test_reset_midload done");
    endtask

    // --------------------------------------------------------------------
    task automatic test_reload_in_work();
        int s0, w0, acc;
        bit ok;
        ack_delay = 1;
        s0 = strobe_data.size();
        step();
        fetch_valid = 1'b1;
        fetch_addr = 4'd5;
        #1;
        acc = cyc;
        checks++;
        if (fetch_ready !== 1'b1) begin
            errors++;
            $display("FAIL reload_accept: got fetch_ready=%b expected 1", fetch_ready);
        end
        step();
        fetch_addr = 4'd7;
        base_addr = 16'h0200;
        start = 1'b1;
        #1;
        checks++;
        if (fetch_ready !== 1'b0) begin
            errors++;
            $display("FAIL reload_ready_low: got %b expected 0", fetch_ready);
        end
        w0 = wr_addr.size();
        step();
        start = 1'b0;
        fetch_valid = 1'b0;
        checks++;
        if (init_finished !== 1'b0 || busy !== 1'b1 || fetch_ready !== 1'b0) begin
            errors++;
            $display("FAIL reload_state: got init=%b busy=%b ready=%b expected 0 1 0",
                     init_finished, busy, fetch_ready);
        end
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (strobe_data.size() - s0 !== 1) begin
            errors++;
            $display("FAIL reload_inflight_count: got %0d expected 1", strobe_data.size() - s0);
        end else if (strobe_data[s0] !== 32'hA000_0305 || strobe_cyc[s0] !== acc + 3) begin
            errors++;
            $display("FAIL reload_inflight: got data=%h cyc=%0d expected a0000305 %0d",
                     strobe_data[s0], strobe_cyc[s0], acc + 3);
        end
        wait_init(400, ok);
        checks++;
        if (!ok || wr_addr.size() - w0 !== 16) begin
            errors++;
            $display("FAIL reload_done: got done=%b writes=%0d expected 1 16", ok, wr_addr.size() - w0);
        end
        s0 = strobe_data.size();
        step();
        fetch_valid = 1'b1;
        fetch_addr = 4'd0;
        step();
        fetch_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (strobe_data.size() - s0 !== 1) begin
            errors++;
            $display("FAIL reload_fetch0_count: got %0d expected 1", strobe_data.size() - s0);
        end else if (strobe_data[s0] !== 32'hA000_0200) begin
            errors++;
            $display("FAIL reload_fetch0: got %h expected a0000200", strobe_data[s0]);
        end
        $display("test_reload_in_work done");
    endtask

    // --------------------------------------------------------------------
    task automatic test_delays();
        int w0, a0, r0, nw;
        bit ok;
        int dly[2];
        logic [15:0] bases[2];
        dly[0] = 0; dly[1] = 5;
        bases[0] = 16'h0400; bases[1] = 16'h0600;
        for (int r = 0; r < 2; r++) begin
            ack_delay = dly[r];
            w0 = wr_addr.size(); a0 = ack_addr.size(); r0 = req_len.size();
            do_start(bases[r]);
            ok = 1'b0;
            for (int k = 0; k < 600; k++) begin
                if (init_finished) begin
                    ok = 1'b1;
                    break;
                end
                nw = wr_addr.size() - w0;
                // stray start pulses in LOAD_REQ, LOAD_WR and DRAIN
                start = (mem_req && (k % 3 == 1)) ||
                        (busy && !mem_req && nw < 16 && (k % 2 == 0)) ||
                        (busy && !mem_req && nw == 16);
                base_addr = 16'h0555;
                step();
            end
            start = 1'b0;
            checks++;
            if (!ok || wr_addr.size() - w0 !== 16 || ack_addr.size() - a0 !== 16) begin
                errors++;
                $display("FAIL delay%0d_load: got done=%b writes=%0d acks=%0d expected 1 16 16",
                         dly[r], ok, wr_addr.size() - w0, ack_addr.size() - a0);
            end else begin
                for (int i = 0; i < 16; i++) begin
                    checks++;
                    if (ack_addr[a0+i] !== bases[r] + 16'(i) || req_len[r0+i] !== dly[r] + 1 ||
                        wr_addr[w0+i] !== 4'(i)) begin
                        errors++;
                        $display("FAIL delay%0d_entry[%0d]: got mem_addr=%h req_cycles=%0d idx=%0d expected %h %0d %0d",
                                 dly[r], i, ack_addr[a0+i], req_len[r0+i], wr_addr[w0+i],
                                 bases[r] + 16'(i), dly[r] + 1, i);
                    end
                end
            end
            for (int i = 0; i < 3; i++) step();
            checks++;
            if (busy !== 1'b0 || init_finished !== 1'b1 || wr_addr.size() - w0 !== 16) begin
                errors++;
                $display("FAIL delay%0d_stays_work: got busy=%b init=%b writes=%0d expected 0 1 16",
                         dly[r], busy, init_finished, wr_addr.size() - w0);
            end
        end
        checks++;
        if (max_run !== 1) begin
            errors++;
            $display("FAIL delays_pulse_width: got %0d expected 1", max_run);
        end
        $display("test_delays done");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_basic();
        test_back_to_back();
        test_wrap();
        test_reset_midload();
        test_reload_in_work();
        test_delays();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
